ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single `RAM_wrapper` data memory between two requesters: port 0 is the `core`, port 1 is a loader/debug master. It latches one request at a time and issues it to the RAM as a one-cycle enable pulse. It waits out `busy`, with a timeout, and returns read data with a one-cycle acknowledge. It sits inside `cpu` between the requesters and `ram_memory`, replacing the core's direct connection.

## Interface
- `DW`, default `DATA_WIDTH`: data width.
- `AW`, default `BUS_WIDTH`: address width.
- `TIMEOUT_CYC`, default 15: maximum WAIT cycles with `ram_busy` high before an error completion. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: request from port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in AW: request address.
- `wdata0`, `wdata1` in DW: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `err0`, `err1` out 1: timeout flag, valid only with the matching ack.
- `rdata0`, `rdata1` out DW: read data, valid only with the matching ack.
- `ram_en` out 2: connects to `RAM_wrapper.en`. `[1]` = write, `[0]` = read.
- `ram_addr_rd`, `ram_addr_wr` out AW: both driven with the latched address.
- `ram_dwrite` out DW: latched write data.
- `ram_dout` in DW: RAM read data.
- `ram_busy` in 1: RAM operation in progress.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `reqN` is sampled high, select a winner.
  - Latch the winner's `we`, `addr`, `wdata` and index, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - Drive `ram_en` = `{we, ~we}` for the latched op.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - `ram_en` = 0.
  - If `ram_busy` = 0: capture `ram_dout` (reads only), set err = 0, go to RESP.
  - Else, if the counter equals `TIMEOUT_CYC - 1`: set err = 1, set rdata = 0, go to RESP.
  - Else increment the counter.
  - Counter width is `$clog2(TIMEOUT_CYC+1)`. It saturates and never wraps.
- **RESP** (exactly 1 cycle)
  - `ackN` = 1 and `errN` = latched err for the granted port only.
  - `rdataN` holds the captured data.
  - Go to IDLE.
- Requester rules:
  - Hold `req`, `we`, `addr`, `wdata` stable until `ack` is seen.
  - A `req` still high in the cycle after `ack` is a new request.
- If `req` drops before `ack`, the latched operation still completes and `ack` still pulses.
- The non-granted port's `req` is ignored until the arbiter returns to IDLE. It is never dropped silently.
- `rdataN` holds its last value between acks. For writes, `rdataN` = 0.
- Asserting `rstn` low in any state:
  - FSM goes to IDLE immediately.
  - Any in-flight operation is abandoned with no ack.
  - The round-robin pointer resets.

## Timing
- Reset values: all `ack`/`err` = 0, all `rdata` = 0, `ram_en` = 0, `ram_addr_*` = 0, `ram_dwrite` = 0, state = IDLE, counter = 0.
- All outputs are registered or decoded from state only. There is no combinational path from `req`/`ram_busy` to outputs.
- Minimum latency, with `req` sampled at edge 0 and `ram_busy` low:
  - `ram_en` pulses in cycle 1 (ISSUE).
  - WAIT occupies cycle 2.
  - `ack` is high in cycle 3.
  - Total: 4 cycles per transaction including the return to IDLE.
- Each busy cycle in WAIT adds 1 cycle of latency.
- Timeout: `ack`+`err` arrive `TIMEOUT_CYC` WAIT cycles after ISSUE.
- Back-to-back: a request held across RESP is re-sampled in IDLE. Peak throughput is one transaction per 4 cycles.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration with a 1-bit last-grant pointer.
  - When both requesters are high, the port not granted last wins.
  - A single requester always wins.
  - The pointer resets to 1, so port 0 wins the first tie.
- `RAM_ARB_ROUND_ROBIN_EN` not defined:
  - Fixed priority: port 0 always wins a tie.
  - Port 1 can starve.
  - No pointer register exists.

## Test plan
- **Single read, port 0.** Preload RAM[0x05]=0x3C, `ram_busy` low, `req0`=1 `we0`=0 `addr0`=0x05 -> `ram_en`=2'b01 in cycle 1, `ack0`=1 with `rdata0`=0x3C in cycle 3, `ack1` stays 0.
- **Write then read, port 1.** Write 0xA5 to addr 0x12 via port 1, then read it back -> `ram_en`=2'b10 on the write, read returns 0xA5, `err1`=0.
- **Tie.** `req0` and `req1` both held high for 4 transactions -> round-robin build grants 0,1,0,1; fixed-priority build grants 0,0,0,0.
- **Busy stretch.** `ram_busy` held high for 3 WAIT cycles -> `ack` at cycle 6, data correct, `err`=0.
- **Timeout.** `ram_busy` stuck high, `TIMEOUT_CYC`=15 -> `ack0`=1, `err0`=1, `rdata0`=0 exactly 15 WAIT cycles after ISSUE, then IDLE.
- **Reset mid-WAIT.** `rstn` pulsed low during WAIT -> all outputs 0 asynchronously, no ack, next request served normally with port 0 winning a tie.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared data RAM.
// The master modport is the environment side; the slave modport is the arbiter.
interface ram_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    // Handshake: a requester raises reqN and holds reqN/weN/addrN/wdataN stable
    // until ackN pulses for exactly one cycle; errN/rdataN are meaningful only
    // with ackN, and a req still high in the cycle after ack is a new request.
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic          err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [1:0]    ram_en;
    logic [AW-1:0] ram_addr_rd, ram_addr_wr;
    logic [DW-1:0] ram_dwrite;
    logic [DW-1:0] ram_dout;
    logic          ram_busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  ram_en, ram_addr_rd, ram_addr_wr, ram_dwrite,
        output ram_dout, ram_busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output ram_en, ram_addr_rd, ram_addr_wr, ram_dwrite,
        input  ram_dout, ram_busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single data RAM: IDLE -> ISSUE -> WAIT -> RESP.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rstn,
    ram_arbiter_if.slave       io_bus,
    output logic [1:0]         o_dbg_state
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_gnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_ram_en;
    logic          r_ack0, r_ack1;
    logic          r_err0, r_err1;
    logic [DW-1:0] r_rdata0, r_rdata1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic          r_last;
`endif

    logic          w_any;
    logic          w_winner;
    logic          w_cpl;
    logic          w_cpl_err;
    logic [DW-1:0] w_cpl_data;

    always_comb begin
        w_any = io_bus.req0 | io_bus.req1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        // On a tie the port that did not win last time goes next.
        w_winner = (io_bus.req0 && io_bus.req1) ? ~r_last : ~io_bus.req0;
`else
        w_winner = ~io_bus.req0;
`endif
        w_cpl      = !io_bus.ram_busy || (r_cnt == CNT_LAST);
        w_cpl_err  = io_bus.ram_busy;
        w_cpl_data = (io_bus.ram_busy || r_we) ? '0 : io_bus.ram_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ram_en <= 2'b00;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_last   <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_winner;
                        r_we     <= w_winner ? io_bus.we1 : io_bus.we0;
                        r_addr   <= w_winner ? io_bus.addr1 : io_bus.addr0;
                        r_wdata  <= w_winner ? io_bus.wdata1 : io_bus.wdata0;
                        r_ram_en <= w_winner ? {io_bus.we1, ~io_bus.we1}
                                             : {io_bus.we0, ~io_bus.we0};
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        r_last   <= w_winner;
`endif
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ram_en <= 2'b00;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_cpl) begin
                        if (r_gnt) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= w_cpl_err;
                            r_rdata1 <= w_cpl_data;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= w_cpl_err;
                            r_rdata0 <= w_cpl_data;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.ack0        = r_ack0;
    assign io_bus.ack1        = r_ack1;
    assign io_bus.err0        = r_err0;
    assign io_bus.err1        = r_err1;
    assign io_bus.rdata0      = r_rdata0;
    assign io_bus.rdata1      = r_rdata1;
    assign io_bus.ram_en      = r_ram_en;
    assign io_bus.ram_addr_rd = r_addr;
    assign io_bus.ram_addr_wr = r_addr;
    assign io_bus.ram_dwrite  = r_wdata;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM (busy stretch / stuck busy).
module tb_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] dbg_state;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    ram_arbiter #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .io_bus      (bus),
        .o_dbg_state (dbg_state)
    );

    // Behavioural RAM: registered read data, optional busy window after each enable.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_dout_r = '0;
    int            busy_cnt = 0;
    int            busy_cycles = 0;
    logic          busy_stuck = 1'b0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.ram_en[1]) mem[bus.ram_addr_wr] <= bus.ram_dwrite;
        if (bus.ram_en[0]) ram_dout_r <= mem[bus.ram_addr_rd];
        if (bus.ram_en != 2'b00) busy_cnt <= busy_cycles;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign bus.ram_dout = ram_dout_r;
    assign bus.ram_busy = busy_stuck | (busy_cnt != 0);

    task automatic drive_req(input int port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic drop_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Counts negedges until any ack; cyc stays -1 if the bound runs out.
    task automatic wait_ack(input int start, output int cyc);
        cyc = -1;
        for (int i = start + 1; i <= 64; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (3) @(negedge clk);
        n_vec++; if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0) begin n_err++; $display("FAIL reset ack/err: got %b want 0000", {bus.ack0, bus.ack1, bus.err0, bus.err1}); end
        n_vec++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin n_err++; $display("FAIL reset rdata: got %h/%h want 00/00", bus.rdata0, bus.rdata1); end
        n_vec++; if (bus.ram_en !== 2'b00) begin n_err++; $display("FAIL reset ram_en: got %b want 00", bus.ram_en); end
        n_vec++; if (bus.ram_addr_rd !== 8'h00 || bus.ram_addr_wr !== 8'h00 || bus.ram_dwrite !== 8'h00) begin n_err++; $display("FAIL reset ram bus: got %h %h %h want 00", bus.ram_addr_rd, bus.ram_addr_wr, bus.ram_dwrite); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset state: got %0d want 0", dbg_state); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        pre_we = 1'b1; pre_addr = 8'h05; pre_data = 8'h3C;
        @(negedge clk);
        pre_we = 1'b0;
        drive_req(0, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        n_vec++; if (bus.ram_en !== 2'b01) begin n_err++; $display("FAIL rd0 ram_en c1: got %b want 01", bus.ram_en); end
        n_vec++; if (bus.ram_addr_rd !== 8'h05) begin n_err++; $display("FAIL rd0 ram_addr_rd: got %h want 05", bus.ram_addr_rd); end
        n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rd0 state c1: got %0d want 1", dbg_state); end
        @(negedge clk);
        n_vec++; if (dbg_state !== 2'd2 || bus.ack0 !== 1'b0 || bus.ram_en !== 2'b00) begin n_err++; $display("FAIL rd0 c2: got state %0d ack0 %b en %b want 2 0 00", dbg_state, bus.ack0, bus.ram_en); end
        @(negedge clk);
        n_vec++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin n_err++; $display("FAIL rd0 ack c3: got %b%b want 10", bus.ack0, bus.ack1); end
        n_vec++; if (bus.rdata0 !== 8'h3C || bus.err0 !== 1'b0) begin n_err++; $display("FAIL rd0 data: got %h err %b want 3c 0", bus.rdata0, bus.err0); end
        drop_reqs();
        @(negedge clk);
        n_vec++; if (dbg_state !== 2'd0 || bus.ack0 !== 1'b0 || bus.rdata0 !== 8'h3C) begin n_err++; $display("FAIL rd0 c4: got state %0d ack0 %b rdata0 %h want 0 0 3c", dbg_state, bus.ack0, bus.rdata0); end
    endtask

    task automatic test_port1_write_read();
        int cyc;
        drive_req(1, 1'b1, 8'h12, 8'hA5);
        @(negedge clk);
        n_vec++; if (bus.ram_en !== 2'b10) begin n_err++; $display("FAIL wr1 ram_en: got %b want 10", bus.ram_en); end
        n_vec++; if (bus.ram_addr_wr !== 8'h12 || bus.ram_dwrite !== 8'hA5) begin n_err++; $display("FAIL wr1 ram bus: got %h %h want 12 a5", bus.ram_addr_wr, bus.ram_dwrite); end
        wait_ack(1, cyc);
        n_vec++; if (cyc !== 3 || bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0) begin n_err++; $display("FAIL wr1 ack: got cyc %0d ack %b%b want 3 01", cyc, bus.ack0, bus.ack1); end
        n_vec++; if (bus.err1 !== 1'b0 || bus.rdata1 !== 8'h00) begin n_err++; $display("FAIL wr1 resp: got err %b rdata %h want 0 00", bus.err1, bus.rdata1); end
        drop_reqs();
        @(negedge clk);
        n_vec++; if (mem[8'h12] !== 8'hA5) begin n_err++; $display("FAIL wr1 mem: got %h want a5", mem[8'h12]); end
        drive_req(1, 1'b0, 8'h12, 8'h00);
        wait_ack(0, cyc);
        n_vec++; if (cyc !== 3 || bus.ack1 !== 1'b1) begin n_err++; $display("FAIL rd1 ack: got cyc %0d ack1 %b want 3 1", cyc, bus.ack1); end
        n_vec++; if (bus.rdata1 !== 8'hA5 || bus.err1 !== 1'b0) begin n_err++; $display("FAIL rd1 data: got %h err %b want a5 0", bus.rdata1, bus.err1); end
        drop_reqs();
        @(negedge clk);
    endtask

    task automatic test_tie();
        int   cyc;
        logic exp_gnt [4];
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_gnt[0] = 1'b0; exp_gnt[1] = 1'b1; exp_gnt[2] = 1'b0; exp_gnt[3] = 1'b1;
`else
        exp_gnt[0] = 1'b0; exp_gnt[1] = 1'b0; exp_gnt[2] = 1'b0; exp_gnt[3] = 1'b0;
`endif
        drive_req(0, 1'b0, 8'h05, 8'h00);
        drive_req(1, 1'b0, 8'h12, 8'h00);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, cyc);
            n_vec++; if (cyc !== ((k == 0) ? 3 : 4)) begin n_err++; $display("FAIL tie%0d latency: got %0d want %0d", k, cyc, (k == 0) ? 3 : 4); end
            n_vec++; if (bus.ack1 !== exp_gnt[k] || bus.ack0 !== ~exp_gnt[k]) begin n_err++; $display("FAIL tie%0d grant: got ack %b%b want port %0d", k, bus.ack0, bus.ack1, exp_gnt[k]); end
            n_vec++; if ((exp_gnt[k] ? bus.rdata1 : bus.rdata0) !== (exp_gnt[k] ? 8'hA5 : 8'h3C)) begin n_err++; $display("FAIL tie%0d data: got %h/%h", k, bus.rdata0, bus.rdata1); end
            if (k == 3) drop_reqs();
        end
        @(negedge clk);
    endtask

    task automatic test_busy_stretch();
        int cyc;
        busy_cycles = 3;
        drive_req(0, 1'b0, 8'h12, 8'h00);
        wait_ack(0, cyc);
        n_vec++; if (cyc !== 6 || bus.ack0 !== 1'b1) begin n_err++; $display("FAIL busy ack: got cyc %0d ack0 %b want 6 1", cyc, bus.ack0); end
        n_vec++; if (bus.rdata0 !== 8'hA5 || bus.err0 !== 1'b0) begin n_err++; $display("FAIL busy data: got %h err %b want a5 0", bus.rdata0, bus.err0); end
        drop_reqs();
        busy_cycles = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        busy_stuck = 1'b1;
        drive_req(0, 1'b0, 8'h05, 8'h00);
        wait_ack(0, cyc);
        n_vec++; if (cyc !== TO + 2 || bus.ack0 !== 1'b1) begin n_err++; $display("FAIL timeout ack: got cyc %0d ack0 %b want %0d 1", cyc, bus.ack0, TO + 2); end
        n_vec++; if (bus.err0 !== 1'b1 || bus.rdata0 !== 8'h00) begin n_err++; $display("FAIL timeout resp: got err %b rdata %h want 1 00", bus.err0, bus.rdata0); end
        drop_reqs();
        busy_stuck = 1'b0;
        @(negedge clk);
        n_vec++; if (dbg_state !== 2'd0 || bus.ack0 !== 1'b0 || bus.err0 !== 1'b0) begin n_err++; $display("FAIL timeout after: got state %0d ack %b err %b want 0 0 0", dbg_state, bus.ack0, bus.err0); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        int acks;
        busy_stuck = 1'b1;
        drive_req(0, 1'b1, 8'h33, 8'h5A);
        repeat (3) @(negedge clk);
        n_vec++; if (dbg_state !== 2'd2 || bus.ram_addr_rd !== 8'h33) begin n_err++; $display("FAIL rst pre: got state %0d addr %h want 2 33", dbg_state, bus.ram_addr_rd); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst state: got %0d want 0", dbg_state); end
        n_vec++; if (bus.ram_addr_rd !== 8'h00 || bus.ram_addr_wr !== 8'h00 || bus.ram_dwrite !== 8'h00 || bus.ram_en !== 2'b00) begin n_err++; $display("FAIL rst ram bus: got %h %h %h %b want 0", bus.ram_addr_rd, bus.ram_addr_wr, bus.ram_dwrite, bus.ram_en); end
        n_vec++; if (bus.rdata1 !== 8'h00 || bus.rdata0 !== 8'h00 || bus.ack0 !== 1'b0) begin n_err++; $display("FAIL rst resp: got %h %h ack0 %b want 00 00 0", bus.rdata0, bus.rdata1, bus.ack0); end
        drop_reqs();
        busy_stuck = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
        end
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL rst no ack: got %0d acks want 0", acks); end
        drive_req(0, 1'b0, 8'h05, 8'h00);
        drive_req(1, 1'b0, 8'h12, 8'h00);
        wait_ack(0, cyc);
        n_vec++; if (cyc !== 3 || bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin n_err++; $display("FAIL rst tie: got cyc %0d ack %b%b want 3 10", cyc, bus.ack0, bus.ack1); end
        n_vec++; if (bus.rdata0 !== 8'h3C) begin n_err++; $display("FAIL rst tie data: got %h want 3c", bus.rdata0); end
        drop_reqs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_port1_write_read();
        test_tie();
        test_busy_stretch();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
